// File: rtl/gsim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gsim_pkg: shared types and constants for the solver output path.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package gsim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } drain_state_t;

  localparam int Q_IN_FRAC   = 16;
  localparam int N_WORDS_DEF = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(N_WORDS_DEF);

endpackage
`default_nettype wire

// File: rtl/q_round_sat.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | q_round_sat: round-half-up right shift by SH, then signed saturate. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module q_round_sat #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SH    = 8
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int c_ext_w = IN_W + 1;
  localparam logic signed [c_ext_w-1:0] c_max = {{(c_ext_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [c_ext_w-1:0] c_min = {{(c_ext_w-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [c_ext_w-1:0] w_ext;
  logic signed [c_ext_w-1:0] w_rnd;
  logic signed [c_ext_w-1:0] w_shr;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign w_ext = {in_data[IN_W-1], in_data};

  generate
    if (SH > 0) begin : g_round
      localparam logic signed [c_ext_w-1:0] c_half = c_ext_w'(1) << (SH - 1);
      assign w_rnd = w_ext + c_half;
    end else begin : g_no_round
      assign w_rnd = w_ext;
    end
  endgenerate

  assign w_shr = w_rnd >>> SH;

  always_comb begin
    out_sat  = 1'b0;
    out_data = w_shr[OUT_W-1:0];
    if (w_shr > c_max) begin
      out_sat  = 1'b1;
      out_data = c_max[OUT_W-1:0];
    end else if (w_shr < c_min) begin
      out_sat  = 1'b1;
      out_data = c_min[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/gsim_result_drain.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gsim_result_drain: captures a fixed-rate solution burst, then      |
// | drains it rounded/saturated over ready/valid.  Rev 1.0              |
// +--------------------------------------------------------------------+
module gsim_result_drain
  import gsim_pkg::*;
#(
  parameter int N_WORDS  = N_WORDS_DEF,
  parameter int IN_W     = 32,
  parameter int OUT_W    = 16,
  parameter int FRAC_OUT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(N_WORDS)-1:0] out_idx,
  output logic                       out_sat,
  output logic                       frame_done,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int c_idx_w = idx_width(N_WORDS);
  localparam int c_sh    = Q_IN_FRAC - FRAC_OUT;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(N_WORDS - 1);

  drain_state_t       r_state;
  logic [c_idx_w-1:0] r_wr_ptr;
  logic [c_idx_w-1:0] r_rd_ptr;
  logic               r_out_valid;
  logic               r_overflow;
  logic               r_discard;
  logic [IN_W-1:0]    r_buf [N_WORDS];

  logic               w_wr_en;
  logic [c_idx_w-1:0] w_wr_addr;
  logic               w_accept;
  logic [OUT_W-1:0]   w_conv_data;
  logic               w_conv_sat;

  assign w_accept  = r_out_valid && out_ready;
  assign w_wr_en   = in_valid && (((r_state == ST_IDLE) && !r_discard) || (r_state == ST_FILL));
  assign w_wr_addr = (r_state == ST_IDLE) ? '0 : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_addr] <= in_data;
  end

  // r_discard swallows the tail of an overrun burst until the solver goes quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      if (ovf_clr)   r_overflow <= 1'b0;
      if (!in_valid) r_discard  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_en) begin
            r_wr_ptr <= c_idx_w'(1);
            r_state  <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            if (r_wr_ptr == c_last) begin
              r_state     <= ST_DRAIN;
              r_wr_ptr    <= '0;
              r_rd_ptr    <= '0;
              r_out_valid <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + c_idx_w'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (in_valid) begin
            r_overflow <= 1'b1;
            r_discard  <= 1'b1;
          end
          if (w_accept) begin
            if (r_rd_ptr == c_last) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_rd_ptr    <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + c_idx_w'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  q_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SH    (c_sh)
  ) u_conv (
    .in_data  (r_buf[r_rd_ptr]),
    .out_data (w_conv_data),
    .out_sat  (w_conv_sat)
  );

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_valid ? w_conv_data : '0;
  assign out_idx    = r_out_valid ? r_rd_ptr : '0;
  assign out_sat    = r_out_valid && w_conv_sat;
  assign frame_done = w_accept && (r_rd_ptr == c_last);
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_gsim_result_drain.sv
`default_nettype none
// Scoreboard bench for gsim_result_drain: stimulus feeds a frame-level model,
// a negedge monitor compares every presented word against the expected queue.
module tb_gsim_result_drain;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        out_sat;
  logic        frame_done;
  logic        overflow;
  logic        ovf_clr;

  always #5 clk = ~clk;

  gsim_result_drain #(
    .N_WORDS  (16),
    .IN_W     (32),
    .OUT_W    (16),
    .FRAC_OUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_sat    (out_sat),
    .frame_done (frame_done),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  idx;
    bit          sat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_fill[$];
  int          m_left = 0;
  int          m_frames = 0;
  bit          m_discard = 0;
  bit          m_ovf = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fd = 0;
  bit          mon_en = 0;
  bit          ready_rand = 0;
  logic [31:0] frame_buf [N];

  // Q16.16 -> Q8.8 by real arithmetic: floor(x/256 + 0.5), then clamp.
  function automatic exp_t ref_conv(input logic [31:0] x, input int idx);
    exp_t e;
    int   sx;
    real  v;
    sx = $signed(x);
    v  = $floor(real'(sx) / 256.0 + 0.5);
    if (v > 32767.0) begin
      e.d = 16'h7FFF; e.sat = 1'b1;
    end else if (v < -32768.0) begin
      e.d = 16'h8000; e.sat = 1'b1;
    end else begin
      e.d = 16'(int'(v)); e.sat = 1'b0;
    end
    e.idx = 4'(idx);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_fill.delete();
      exp_q.delete();
      m_left    = 0;
      m_discard = 0;
      m_ovf     = 0;
    end else begin
      bit acc;
      acc = (m_left > 0) && out_ready;
      if (ovf_clr) m_ovf = 0;
      if (in_valid) begin
        if (m_left > 0) begin
          m_ovf     = 1;
          m_discard = 1;
        end else if (!m_discard) begin
          m_fill.push_back(in_data);
          if (m_fill.size() == N) begin
            foreach (m_fill[k]) exp_q.push_back(ref_conv(m_fill[k], k));
            m_fill.delete();
            m_left = N;
            m_frames++;
          end
        end
      end else begin
        m_discard = 0;
      end
      if (acc) m_left--;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = exp_q.size() > 0;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (ev) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0].d));
        chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
        chk("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
        chk("frame_done", 32'(frame_done), 32'(out_ready && (exp_q[0].idx == 4'd15)));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("idle_outputs", 32'({out_data, out_idx, out_sat, frame_done}), 32'd0);
      end
      if (frame_done) n_fd++;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_frame(input int gap_pct);
    for (int k = 0; k < N; k++) begin
      while ($urandom_range(0, 99) < gap_pct) cyc();
      send_word(frame_buf[k]);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) frame_buf[k] = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || m_left > 0) && n < 1000) begin
      cyc();
      n++;
    end
    chk("drain_in_time", 32'(n < 1000), 32'd1);
    cyc();
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ovf_clr  = 1'b0;
    repeat (3) cyc();
    mon_en = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();

    for (int k = 0; k < N; k++) frame_buf[k] = 32'(k + 1) << 16;
    send_frame(0);
    wait_drain();

    rand_frame();
    frame_buf[0] = 32'h0001_8000;
    frame_buf[1] = 32'hFFFF_FF80;
    frame_buf[2] = 32'hFFFF_FF7F;
    frame_buf[3] = 32'h0000_0080;
    frame_buf[4] = 32'h7FFF_FFFF;
    frame_buf[5] = 32'h8000_0000;
    frame_buf[6] = 32'h007F_FF00;
    frame_buf[7] = 32'hFF80_0000;
    send_frame(0);
    wait_drain();

    ready_rand = 1'b1;
    rand_frame();
    send_frame(20);
    wait_drain();

    // Overrun starting while idx 5 is presented; clear and set collide on word 2.
    ready_rand = 1'b0;
    rand_frame();
    send_frame(0);
    n = 0;
    while (m_left != 11 && n < 100) begin
      cyc();
      n++;
    end
    chk("reach_idx5", 32'(m_left), 32'd11);
    send_word($urandom);
    ovf_clr = 1'b1;
    send_word($urandom);
    ovf_clr = 1'b0;
    repeat (4) send_word($urandom);
    wait_drain();
    repeat (2) cyc();
    ready_rand = 1'b1;
    rand_frame();
    send_frame(0);
    wait_drain();
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    cyc();

    ready_rand = 1'b0;
    for (int k = 0; k < 7; k++) send_word($urandom);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    rand_frame();
    send_frame(0);
    wait_drain();

    ready_rand = 1'b1;
    repeat (4) begin
      rand_frame();
      send_frame(25);
      wait_drain();
    end

    chk("frames_completed", 32'(n_fd), 32'(m_frames));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gsim_result_drain.md
# gsim_result_drain

Downstream output stage for the Gauss-Seidel solver. It captures the 16-word Q16.16 solution burst, which arrives one word per cycle and cannot be stalled. It buffers the full frame, then drains it over a ready/valid stream. Each word is rounded and saturated to a narrower signed fixed-point format. It decouples the solver's fixed-rate burst from a consumer that may apply backpressure, and flags frames lost to overrun.

## Interface
- `N_WORDS`, 16: words per frame (power of two).
- `IN_W`, 32: input word width, signed Q16.16.
- `OUT_W`, 16: output word width, signed.
- `FRAC_OUT`, 8: fractional bits of the output word (0..16).

- `clk`: input, 1 bit, sole clock, rising edge.
- `reset`: input, 1 bit. Reset is synchronous and active-high.
- `in_valid`: input, 1 bit. Solver result strobe; no ready is returned.
- `in_data`: input, `IN_W` bits. Solution word, signed Q16.16, frame order x1..x16.
- `out_valid`: output, 1 bit. Output word available.
- `out_ready`: input, 1 bit. Consumer accepts the word.
- `out_data`: output, `OUT_W` bits. Rounded and saturated word.
- `out_idx`: output, log2(`N_WORDS`) bits. Index of `out_data` within the frame.
- `out_sat`: output, 1 bit. The current word was clipped.
- `frame_done`: output, 1 bit. One-cycle pulse when the last word is accepted.
- `overflow`: output, 1 bit. Sticky flag; a word arrived while draining.
- `ovf_clr`: input, 1 bit. Clears `overflow`.

## Operation
- FSM states:
  - IDLE: wait for the first word.
  - FILL: capturing the frame.
  - DRAIN: presenting the frame to the consumer.
- IDLE → FILL: on `in_valid`, write the word to buf[0] and set `wr_ptr`=1.
- FILL: each `in_valid` writes buf[`wr_ptr`] and increments `wr_ptr`. Gaps (`in_valid`=0) are tolerated and hold state.
- FILL → DRAIN: on the write with `wr_ptr`=`N_WORDS`-1. `rd_ptr` is set to 0.
- DRAIN: `out_valid`=1. `out_data`/`out_sat` are conversions of buf[`rd_ptr`]; `out_idx`=`rd_ptr`.
  - Handshake: `out_valid`&&`out_ready` advances `rd_ptr`.
  - On acceptance of `rd_ptr`=`N_WORDS`-1: pulse `frame_done` and go to IDLE.
- Conversion, with SH = 16 − `FRAC_OUT`:
  - Extend to `IN_W`+1 bits.
  - Add 2^(SH−1) when SH>0 (round half up).
  - Arithmetic shift right by SH.
  - Saturate to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1]. `out_sat`=1 iff clipped.
- `out_data`, `out_idx` and `out_sat` are stable while `out_valid`&&!`out_ready`. They are don't-care when `out_valid`=0, but driven to 0 there.
- Overrun:
  - `in_valid` during DRAIN sets `overflow`, and the word is discarded.
  - The buffer and drain are unaffected.
  - The remainder of that burst is also discarded; capture restarts only from IDLE.
- `ovf_clr` and an overrun word in the same cycle: `overflow` stays 1 (set wins).
- Reset mid-frame aborts everything; partial buffer contents are ignored.

## Timing
- Reset values:
  - State IDLE, `wr_ptr`=`rd_ptr`=0.
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_sat`=0, `frame_done`=0, `overflow`=0.
- Latency: `out_valid` rises the cycle after the 16th word is captured. The first word is presented combinationally from the registered buffer.
- Throughput: one word per cycle with `out_ready` held high. A frame drains in 16 cycles, and `frame_done` is asserted coincident with the last accepting edge's cycle.
- Returning to IDLE takes effect the cycle after the last acceptance. A word arriving in that same acceptance cycle counts as an overrun.
- Back-to-back frames need at least one idle cycle between the last acceptance and the next burst's first word.

## Structure
- Shared package `gsim_pkg`:
  - drain state enum (IDLE/FILL/DRAIN);
  - `Q_IN_FRAC`=16;
  - the `N_WORDS` default;
  - the index-width helper constant.
- One sub-module, `q_round_sat`. It is parameterised by `IN_W`/`OUT_W`/SH and is purely combinational: it takes `in_data` and produces `out_data` and `out_sat`.
- The top level holds the FSM, the pointers, the 16×`IN_W` buffer and the overflow flag.

## Test plan
- Basic frame: 16 consecutive words x_k = k·0x0001_0000, `out_ready`=1.
  - Required: `out_data` = k·256 (0x0100…0x1000), `out_idx` 0..15, `frame_done` on idx 15, `out_sat`=0.
- Rounding:
  - 0x0001_8000 → 0x0180.
  - 0xFFFF_FF80 → 0x0000.
  - 0xFFFF_FF7F → 0xFFFF.
  - 0x0000_0080 → 0x0001.
- Saturation:
  - 0x7FFF_FFFF → 0x7FFF with `out_sat`=1.
  - 0x8000_0000 → 0x8000 with `out_sat`=1.
  - 0x007F_FF00 → 0x7FFF with `out_sat`=0.
- Backpressure: toggle `out_ready` randomly. Required: outputs hold while stalled, 16 accepted words in order, no duplicates.
- Overrun: a second burst starts while DRAIN is at idx 5.
  - Required: `overflow`=1, drain completes unchanged, the next frame after IDLE is captured correctly.
  - `ovf_clr` then clears the flag.
- Reset mid-FILL after 7 words. Required: all outputs at reset values next cycle, and a fresh 16-word frame drains correctly.
